// File: rtl/clz_clocked_pkg.sv
// Shared constants and helpers for the clocked leading-zero counter.
// The RNG field widths live here so the uniform-to-float stage and this
// unit agree on how wide the exponent field of a raw draw is.
package clz_clocked_pkg;

  // Uniform RNG word layout (LVDS comparator generator).
  localparam int URNG_BX     = 32;
  localparam int RNG_EXP_BW  = 8;
  localparam int RNG_MANT_BW = 23;

  // Ceiling log2; callers guarantee n >= 2.
  function automatic int CLOG2(input int n);
    return $clog2(n);
  endfunction

  function automatic int MAX(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clz_clocked_if.sv
// Operand/result bundle between the uniform-to-float stage (master)
// and the leading-zero counter (slave).
interface clz_clocked_if
  import clz_clocked_pkg::*;
#(
  parameter int bits_in = RNG_EXP_BW
);
  localparam int W = CLOG2(bits_in);

  logic [bits_in-1:0] b;
  logic               ready;
  logic               vout;
  logic [W-1:0]       pout;

  modport master (output b, input ready, input vout, input pout);
  modport slave  (input b, output ready, output vout, output pout);

endinterface

// File: rtl/clz_clocked_search_step.sv
// One binary-search step of the leading-zero count: if the top 2**k bits
// of the window are all zero, add 2**k to the count and shift them out.
module clz_search_step
  import clz_clocked_pkg::*;
#(
  parameter  int P = 8,
  localparam int W = CLOG2(P)
) (
  input  logic [P-1:0] s,
  input  logic [W-1:0] k,
  input  logic [W-1:0] c,
  output logic [P-1:0] s_next,
  output logic [W-1:0] c_next
);

  // P is a power of two, so it needs W+1 bits.
  localparam logic [W:0] PW = (W+1)'(P);

  logic [W:0] span;
  logic       top_zero;

  // k never exceeds W-1, so span is at most P/2 and fits the count width.
  assign span     = (W+1)'(1) << k;
  assign top_zero = ((s >> (PW - span)) == '0);
  assign s_next   = top_zero ? (s << span) : s;
  assign c_next   = top_zero ? (c + span[W-1:0]) : c;

endmodule

// File: rtl/clz_clocked.sv
// Multi-cycle leading-zero counter. Captures an operand whenever idle,
// resolves one binary-search step per clock and pulses vout with the
// count. All-zero operands finish silently so the consumer redraws.
// The io interface must be instantiated with the same bits_in.
module clz_clocked
  import clz_clocked_pkg::*;
#(
  parameter int bits_in = RNG_EXP_BW
) (
  input  logic         clk,
  input  logic         rst,
  clz_clocked_if.slave io
);

  localparam int W = CLOG2(bits_in);
  localparam int P = 2 ** W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [W-1:0] K_FIRST = W'(W - 1);

  logic [0:0]   state;
  logic [P-1:0] s_q;
  logic [W-1:0] c_q;
  logic [W-1:0] k_q;
  logic         z_q;
  logic         ready_q;
  logic         vout_q;
  logic [W-1:0] pout_q;

  logic [P-1:0] b_ext;
  logic [P-1:0] s_cap;
  logic [P-1:0] s_nxt;
  logic [W-1:0] c_nxt;

  // Left-justify the operand; the pad bits sit below the LSB so they are
  // only reached once every real bit has been counted as zero.
  assign b_ext = P'(io.b);
  assign s_cap = b_ext << (P - bits_in);

  // Single search-step datapath, reused on every BUSY cycle.
  clz_search_step #(.P(P)) u_step (
    .s      (s_q),
    .k      (k_q),
    .c      (c_q),
    .s_next (s_nxt),
    .c_next (c_nxt)
  );

  // Control FSM and datapath registers; outputs come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      z_q     <= 1'b0;
      ready_q <= 1'b1;
      vout_q  <= 1'b0;
      pout_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_q     <= s_cap;
          z_q     <= (io.b == '0);
          c_q     <= '0;
          k_q     <= K_FIRST;
          ready_q <= 1'b0;
          vout_q  <= 1'b0;
          state   <= BUSY;
        end
        default: begin
          s_q <= s_nxt;
          c_q <= c_nxt;
          if (k_q == '0) begin
            // Zero operand: count would be P and is meaningless, keep pout.
            if (!z_q) pout_q <= c_nxt;
            vout_q  <= !z_q;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign io.ready = ready_q;
  assign io.vout  = vout_q;
  assign io.pout  = pout_q;

endmodule

// File: tb/tb_clz_clocked.sv
// Directed bench for clz_clocked: one 8-bit and one 5-bit instance.
module tb_clz_clocked;

  logic clk;
  logic rst;

  int errs   = 0;
  int checks = 0;

  clz_clocked_if #(.bits_in(8)) io8 ();
  clz_clocked_if #(.bits_in(5)) io5 ();

  clz_clocked #(.bits_in(8)) dut8 (.clk(clk), .rst(rst), .io(io8));
  clz_clocked #(.bits_in(5)) dut5 (.clk(clk), .rst(rst), .io(io5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges for the 8-bit unit to go idle.
  task automatic wait_ready8(input string tag);
    int n = 0;
    while (io8.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_ready_timeout"}, 32'(io8.ready), 32'd1);
  endtask

  // Present b while idle; check ready low for 3 cycles, then the result.
  // The vout-clears check for this op happens in the next call.
  task automatic run8(input string tag, input logic [7:0] b, input logic [2:0] exp_p,
                      input logic exp_v, input bit toggle);
    wait_ready8(tag);
    io8.b = b;
    @(negedge clk);
    chk({tag, "_busy0"}, 32'(io8.ready), 32'd0);
    chk({tag, "_vclr"},  32'(io8.vout),  32'd0);
    for (int i = 1; i < 3; i++) begin
      if (toggle) io8.b = 8'($urandom);
      @(negedge clk);
      chk({tag, "_busy"}, 32'(io8.ready), 32'd0);
      chk({tag, "_vlow"}, 32'(io8.vout),  32'd0);
    end
    if (toggle) io8.b = 8'($urandom);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(io8.ready), 32'd1);
    chk({tag, "_vout"},  32'(io8.vout),  32'(exp_v));
    chk({tag, "_pout"},  32'(io8.pout),  32'(exp_p));
  endtask

  task automatic run5(input string tag, input logic [4:0] b, input logic [2:0] exp_p);
    int n = 0;
    while (io5.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_ready_timeout"}, 32'(io5.ready), 32'd1);
    io5.b = b;
    repeat (3) @(negedge clk);
    chk({tag, "_busy"}, 32'(io5.ready), 32'd0);
    @(negedge clk);
    chk({tag, "_vout"}, 32'(io5.vout), 32'd1);
    chk({tag, "_pout"}, 32'(io5.pout), 32'(exp_p));
  endtask

  initial begin
    rst   = 1'b0;
    io8.b = '0;
    io5.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(io8.ready), 32'd1);
    chk("rst_vout",  32'(io8.vout),  32'd0);
    chk("rst_pout",  32'(io8.pout),  32'd0);
    chk("rst5_pout", 32'(io5.pout),  32'd0);
    rst = 1'b1;

    // Basic count, then back-to-back results 4 cycles apart.
    run8("b16",  8'b0001_0110, 3'd3, 1'b1, 1'b0);
    run8("b80",  8'h80,        3'd0, 1'b1, 1'b0);
    run8("b01",  8'h01,        3'd7, 1'b1, 1'b0);
    // Zero operand: no pulse, pout holds the previous nonzero result.
    run8("b10",  8'h10,        3'd3, 1'b1, 1'b0);
    run8("b00",  8'h00,        3'd3, 1'b0, 1'b0);
    // Operand changes while busy are ignored.
    run8("b20t", 8'h20,        3'd2, 1'b1, 1'b1);
    @(negedge clk);
    chk("b20t_vclr", 32'(io8.vout), 32'd0);

    // Padded width: padding never contributes for nonzero operands.
    run5("b5_01", 5'b00001, 3'd4);
    run5("b5_10", 5'b10000, 3'd0);

    // Asynchronous reset in the middle of a BUSY cycle.
    wait_ready8("arst");
    io8.b = 8'h01;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(io8.ready), 32'd1);
    chk("arst_vout",  32'(io8.vout),  32'd0);
    chk("arst_pout",  32'(io8.pout),  32'd0);
    io8.b = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_nopulse", 32'(io8.vout), 32'd0);
    end
    chk("arst_pout_hold", 32'(io8.pout), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
